// File: rtl/aperture_pkg.sv
// Shared types and constants for the aperture translation table.
// The 2D addressing fields exist only when APERTURE_2D_EN is defined.
package aperture_pkg;

    localparam int NUM_DESC = 16;
    localparam int IDX_W    = 4;

    localparam logic [3:0] DESC_BASE   = 4'd0;
    localparam logic [3:0] DESC_PAGE   = 4'd4;
    localparam logic [3:0] DESC_NPAGES = 4'd5;
    localparam logic [3:0] DESC_STRIDE = 4'd6;
    localparam logic [3:0] DESC_X      = 4'd7;
    localparam logic [3:0] DESC_Y      = 4'd9;
    localparam logic [3:0] DESC_WIDTH  = 4'd11;
    localparam logic [3:0] DESC_HEIGHT = 4'd13;
    localparam logic [3:0] DESC_FLAGS  = 4'd15;

    localparam int FLAG_EN = 0;
    localparam int FLAG_2D = 1;

    typedef struct packed {
        logic [31:0] base;
        logic [7:0]  page;
        logic [7:0]  npages;
        logic        en;
`ifdef APERTURE_2D_EN
        logic        mode2d;
        logic [7:0]  stride;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] width;
        logic [15:0] height;
`endif
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Merge one little-endian descriptor byte into the cached fields.
    function automatic desc_t put_byte(input desc_t d, input logic [3:0] off, input logic [7:0] b);
        desc_t r;
        r = d;
        case (off)
            DESC_BASE:          r.base[7:0]   = b;
            DESC_BASE + 4'd1:   r.base[15:8]  = b;
            DESC_BASE + 4'd2:   r.base[23:16] = b;
            DESC_BASE + 4'd3:   r.base[31:24] = b;
            DESC_PAGE:          r.page        = b;
            DESC_NPAGES:        r.npages      = b;
`ifdef APERTURE_2D_EN
            DESC_STRIDE:        r.stride        = b;
            DESC_X:             r.x[7:0]        = b;
            DESC_X + 4'd1:      r.x[15:8]       = b;
            DESC_Y:             r.y[7:0]        = b;
            DESC_Y + 4'd1:      r.y[15:8]       = b;
            DESC_WIDTH:         r.width[7:0]    = b;
            DESC_WIDTH + 4'd1:  r.width[15:8]   = b;
            DESC_HEIGHT:        r.height[7:0]   = b;
            DESC_HEIGHT + 4'd1: r.height[15:8]  = b;
            DESC_FLAGS: begin
                r.en     = b[FLAG_EN];
                r.mode2d = b[FLAG_2D];
            end
`else
            DESC_FLAGS:         r.en = b[FLAG_EN];
`endif
            default:            r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aperture_match.sv
// One descriptor's page-range compare and window offset.
// Honours the 2D column/row bounds when APERTURE_2D_EN is defined.
module aperture_match (
    input  logic [15:0] addr_i,
    input  logic        en_i,
    input  logic [7:0]  page_i,
    input  logic [7:0]  npages_i,
`ifdef APERTURE_2D_EN
    input  logic        mode2d_i,
    input  logic [15:0] width_i,
    input  logic [15:0] height_i,
`endif
    output logic        hit_o,
    output logic [15:0] off_o
);
    import aperture_pkg::*;

    logic [8:0] limit_s;
    logic       in_range_s;

    // Upper bound is formed in 9 bits so a window near $FF never wraps to page 0.
    always_comb begin
        limit_s    = {1'b0, page_i} + {1'b0, npages_i};
        in_range_s = en_i && (npages_i != 8'd0) && (addr_i[15:8] >= page_i)
                     && ({1'b0, addr_i[15:8]} < limit_s);
        off_o      = addr_i - {page_i, 8'h00};
`ifdef APERTURE_2D_EN
        if (mode2d_i) begin
            hit_o = in_range_s && ({8'h00, off_o[7:0]} < width_i)
                    && ({8'h00, off_o[15:8]} < height_i);
        end else begin
            hit_o = in_range_s;
        end
`else
        hit_o = in_range_s;
`endif
    end

endmodule

// File: rtl/aperture_table.sv
// Descriptor cache loaded from the config RAM plus a 2-stage first-match address translator.
// Optional 2D aperture mode is enabled by defining APERTURE_2D_EN.
module aperture_table #(
    parameter int NUM_DESC = 16,
    parameter int SDRAM_AW = 32
) (
    input  logic                clk200,
    input  logic                rst,
    input  logic                reload,
    output logic [8:0]          ram_addr,
    input  logic [7:0]          ram_rdata,
    output logic                busy,
    output logic                loaded,
    input  logic                lk_valid,
    input  logic [15:0]         lk_addr,
    output logic                lk_done,
    output logic                lk_hit,
    output logic [3:0]          lk_idx,
    output logic [SDRAM_AW-1:0] lk_sdram
);
    import aperture_pkg::*;

    state_t      state_q;
    logic [8:0]  lcnt_q;
    logic [8:0]  ram_addr_q;
    logic        busy_q;
    logic        loaded_q;
    desc_t       desc_q [NUM_DESC];
    logic [7:0]  cap_s;

    logic [NUM_DESC-1:0] hit_vec_s;
    logic [15:0]         off_s [NUM_DESC];
    logic                win_hit_s;
    logic [3:0]          win_idx_s;
    logic [15:0]         win_off_s;

    logic                v1_q;
    logic                hit1_q;
    logic [3:0]          idx1_q;
    logic [15:0]         off1_q;
    desc_t               sel_s;
    logic [SDRAM_AW-1:0] sdram_d;

    logic                lk_done_q;
    logic                lk_hit_q;
    logic [3:0]          lk_idx_q;
    logic [SDRAM_AW-1:0] lk_sdram_q;

    // RAM data lags the presented address by one cycle, so capture the byte for lcnt-1.
    assign cap_s = lcnt_q[7:0] - 8'd1;

    // Load sequencer: walks the descriptor page and fills the cache.
    always_ff @(posedge clk200) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lcnt_q     <= 9'd0;
            ram_addr_q <= 9'd0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            for (int i = 0; i < NUM_DESC; i++) begin
                desc_q[i] <= '0;
            end
        end else if (reload) begin
            state_q    <= ST_LOAD;
            lcnt_q     <= 9'd0;
            ram_addr_q <= 9'd0;
            busy_q     <= 1'b1;
            loaded_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    lcnt_q <= lcnt_q + 9'd1;
                    if (ram_addr_q != 9'd255) begin
                        ram_addr_q <= ram_addr_q + 9'd1;
                    end
                    if (lcnt_q != 9'd0) begin
                        desc_q[cap_s[7:4]] <= put_byte(desc_q[cap_s[7:4]], cap_s[3:0], ram_rdata);
                    end
                    if (lcnt_q == 9'd256) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        loaded_q   <= 1'b1;
                        ram_addr_q <= 9'd0;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DESC; g++) begin : g_match
        aperture_match u_match (
            .addr_i   (lk_addr),
            .en_i     (desc_q[g].en),
            .page_i   (desc_q[g].page),
            .npages_i (desc_q[g].npages),
`ifdef APERTURE_2D_EN
            .mode2d_i (desc_q[g].mode2d),
            .width_i  (desc_q[g].width),
            .height_i (desc_q[g].height),
`endif
            .hit_o    (hit_vec_s[g]),
            .off_o    (off_s[g])
        );
    end

    // Priority select: scanning downward leaves the lowest matching index.
    always_comb begin
        win_hit_s = 1'b0;
        win_idx_s = 4'd0;
        win_off_s = 16'd0;
        for (int i = NUM_DESC - 1; i >= 0; i--) begin
            if (hit_vec_s[i]) begin
                win_hit_s = 1'b1;
                win_idx_s = i[3:0];
                win_off_s = off_s[i];
            end else begin
                win_hit_s = win_hit_s;
            end
        end
    end

    // Stage-2 address arithmetic for the registered winner.
    always_comb begin
        sel_s = desc_q[idx1_q];
`ifdef APERTURE_2D_EN
        if (sel_s.mode2d) begin
            sdram_d = SDRAM_AW'(sel_s.base)
                    + SDRAM_AW'({({8'd0, ({1'b0, sel_s.y} + {9'd0, off1_q[15:8]})}
                                  * {17'd0, sel_s.stride}), 8'h00})
                    + SDRAM_AW'(sel_s.x) + SDRAM_AW'(off1_q[7:0]);
        end else begin
            sdram_d = SDRAM_AW'(sel_s.base) + SDRAM_AW'(off1_q);
        end
`else
        sdram_d = SDRAM_AW'(sel_s.base) + SDRAM_AW'(off1_q);
`endif
    end

    // Lookup pipeline; results hold between strobes.
    always_ff @(posedge clk200) begin
        if (rst) begin
            v1_q       <= 1'b0;
            hit1_q     <= 1'b0;
            idx1_q     <= 4'd0;
            off1_q     <= 16'd0;
            lk_done_q  <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_idx_q   <= 4'd0;
            lk_sdram_q <= '0;
        end else begin
            v1_q      <= lk_valid;
            hit1_q    <= lk_valid & loaded_q & win_hit_s;
            idx1_q    <= (loaded_q & win_hit_s) ? win_idx_s : 4'd0;
            off1_q    <= win_off_s;
            lk_done_q <= v1_q;
            if (v1_q) begin
                lk_hit_q   <= hit1_q;
                lk_idx_q   <= hit1_q ? idx1_q : 4'd0;
                lk_sdram_q <= hit1_q ? sdram_d : '0;
            end
        end
    end

    assign ram_addr = ram_addr_q;
    assign busy     = busy_q;
    assign loaded   = loaded_q;
    assign lk_done  = lk_done_q;
    assign lk_hit   = lk_hit_q;
    assign lk_idx   = lk_idx_q;
    assign lk_sdram = lk_sdram_q;

endmodule

// File: tb/tb_aperture_table.sv
// Bench for aperture_table: config RAM model, descriptor-level reference lookup, directed + random steps.
module tb_aperture_table;

    logic        clk200 = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_rdata = 8'd0;
    logic        busy;
    logic        loaded;
    logic        lk_valid = 1'b0;
    logic [15:0] lk_addr = 16'd0;
    logic        lk_done;
    logic        lk_hit;
    logic [3:0]  lk_idx;
    logic [31:0] lk_sdram;

    logic [7:0]  mem [512];
    logic [7:0]  tbl [256];
    bit          mdl_loaded = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        last_hit = 1'b0;
    logic [3:0]  last_idx = 4'd0;
    logic [31:0] last_sd = 32'd0;

    aperture_table #(.NUM_DESC(16), .SDRAM_AW(32)) dut (
        .clk200(clk200), .rst(rst), .reload(reload), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .busy(busy), .loaded(loaded), .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_done(lk_done),
        .lk_hit(lk_hit), .lk_idx(lk_idx), .lk_sdram(lk_sdram)
    );

    always #5 clk200 = ~clk200;

    // Registered-read config RAM.
    always @(posedge clk200) ram_rdata <= mem[ram_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input int d, input logic [31:0] base, input logic [7:0] page,
                            input logic [7:0] np, input logic [7:0] stride, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] w, input logic [15:0] h,
                            input logic [7:0] flags);
        int b;
        b = d * 16;
        mem[b]    = base[7:0];  mem[b+1]  = base[15:8]; mem[b+2] = base[23:16]; mem[b+3] = base[31:24];
        mem[b+4]  = page;       mem[b+5]  = np;         mem[b+6] = stride;
        mem[b+7]  = x[7:0];     mem[b+8]  = x[15:8];    mem[b+9] = y[7:0];     mem[b+10] = y[15:8];
        mem[b+11] = w[7:0];     mem[b+12] = w[15:8];    mem[b+13] = h[7:0];    mem[b+14] = h[15:8];
        mem[b+15] = flags;
    endtask

    // Reference: first enabled descriptor whose page window holds the address.
    function automatic void ref_lookup(input logic [15:0] a, output logic hit,
                                       output logic [3:0] idx, output logic [31:0] sd);
        hit = 1'b0; idx = 4'd0; sd = 32'd0;
        if (!mdl_loaded) return;
        for (int d = 0; d < 16; d++) begin
            int b, page, np, pg, o;
            longint base, sdv;
            bit ok;
            b = d * 16;
            page = int'(tbl[b+4]);
            np = int'(tbl[b+5]);
            pg = int'(a[15:8]);
            base = longint'({tbl[b+3], tbl[b+2], tbl[b+1], tbl[b]});
            o = int'(a) - page * 256;
            ok = (tbl[b+15][0] == 1'b1) && np != 0 && pg >= page && pg < page + np;
            sdv = base + o;
`ifdef APERTURE_2D_EN
            if (tbl[b+15][1] == 1'b1) begin
                int row, col, w, h, x, y, st;
                row = o / 256; col = o % 256;
                st = int'(tbl[b+6]);
                x = int'(tbl[b+7]) + 256 * int'(tbl[b+8]);
                y = int'(tbl[b+9]) + 256 * int'(tbl[b+10]);
                w = int'(tbl[b+11]) + 256 * int'(tbl[b+12]);
                h = int'(tbl[b+13]) + 256 * int'(tbl[b+14]);
                ok = ok && col < w && row < h;
                sdv = base + longint'(y + row) * st * 256 + x + col;
            end
`endif
            if (ok) begin
                hit = 1'b1;
                idx = d[3:0];
                sd = sdv[31:0];
                break;
            end
        end
    endfunction

    // Call at a negedge; leaves the caller at the negedge after reload was sampled.
    task automatic start_reload;
        reload = 1'b1;
        mdl_loaded = 1'b0;
        @(negedge clk200);
        reload = 1'b0;
    endtask

    task automatic wait_load(input string tag, input int start);
        int cnt;
        cnt = start;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk200);
        end
        check({tag, "_busy_cycles"}, cnt, 257);
        check({tag, "_loaded"}, loaded, 1);
        check({tag, "_ram_addr"}, ram_addr, 0);
        for (int i = 0; i < 256; i++) tbl[i] = mem[i];
        mdl_loaded = 1'b1;
    endtask

    task automatic lookup(input string tag, input logic [15:0] a);
        logic eh;
        logic [3:0] ei;
        logic [31:0] es;
        lk_valid = 1'b1;
        lk_addr = a;
        @(negedge clk200);
        lk_valid = 1'b0;
        lk_addr = 16'($urandom);
        check({tag, "_gap"}, lk_done, 0);
        check({tag, "_hold"}, lk_hit, last_hit);
        @(negedge clk200);
        ref_lookup(a, eh, ei, es);
        check({tag, "_done"}, lk_done, 1);
        check({tag, "_hit"}, lk_hit, eh);
        check({tag, "_idx"}, lk_idx, ei);
        check({tag, "_sdram"}, lk_sdram, es);
        last_hit = eh; last_idx = ei; last_sd = es;
    endtask

    initial begin
        logic        vh [2];
        logic [15:0] ah [2];
        logic        eh;
        logic [3:0]  ei;
        logic [31:0] es;
        logic        nv;
        logic [15:0] na;

        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk200);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_loaded", loaded, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_done", lk_done, 0);
        check("rst_hit", lk_hit, 0);
        check("rst_idx", lk_idx, 0);
        check("rst_sdram", lk_sdram, 0);

        // All-zero table: every lookup misses.
        start_reload();
        wait_load("zero", 0);
        lookup("zero_lk", 16'($urandom));

        // Single linear window.
        set_desc(0, 32'h0001_0000, 8'h40, 8'd4, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        start_reload();
        wait_load("d0", 0);
        lookup("d0_4123", 16'h4123);
        check("d0_4123_const", lk_sdram, 32'h0001_0123);
        lookup("d0_4400", 16'h4400);
        check("d0_4400_miss", lk_hit, 0);

        // Overlapping windows: lowest enabled index wins.
        set_desc(2, 32'h0030_0000, 8'h80, 8'd1, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        set_desc(5, 32'h0050_0000, 8'h80, 8'd2, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        start_reload();
        wait_load("ovl", 0);
        lookup("ovl_a", 16'h8010);
        check("ovl_a_idx_const", lk_idx, 2);
        mem[2*16+15] = 8'h00;
        start_reload();
        wait_load("ovl_dis", 0);
        lookup("ovl_b", 16'h8010);
        check("ovl_b_idx_const", lk_idx, 5);

        // Window at the top of the address space must not wrap.
        set_desc(7, 32'h0020_0000, 8'hFE, 8'd4, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        set_desc(9, 32'h0000_0000, 8'h20, 8'd4, 8'd2, 16'd4, 16'd1, 16'h10, 16'd3, 8'h03);
        start_reload();
        wait_load("top", 0);
        lookup("top_ff05", 16'hFF05);
        check("top_ff05_const", lk_sdram, 32'h0020_0105);
        lookup("top_0005", 16'h0005);
        check("top_0005_miss", lk_hit, 0);

        // 2D descriptor (linear when the feature is compiled out).
        lookup("td_2105", 16'h2105);
`ifdef APERTURE_2D_EN
        check("td_2105_const", lk_sdram, 32'h0000_0409);
`else
        check("td_2105_const", lk_sdram, 32'h0000_0105);
`endif
        lookup("td_2110", 16'h2110);
        lookup("td_2300", 16'h2300);

        // Reload mid-load restarts the walk.
        start_reload();
        repeat (99) @(negedge clk200);
        check("rl_mid_addr", ram_addr, 99);
        check("rl_mid_loaded", loaded, 0);
        start_reload();
        check("rl_restart_addr", ram_addr, 0);
        check("rl_restart_busy", busy, 1);
        check("rl_restart_loaded", loaded, 0);
        lookup("rl_during", 16'h4123);
        wait_load("rl", 2);

        // Random descriptors, then back-to-back random lookups.
        for (int d = 10; d < 16; d++) begin
            set_desc(d, $urandom, 8'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
                     16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
                     16'($urandom_range(0, 300)), 16'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
        end
        start_reload();
        wait_load("rnd", 0);
        eh = last_hit; ei = last_idx; es = last_sd;
        vh[0] = 1'b0; vh[1] = 1'b0; ah[0] = 16'd0; ah[1] = 16'd0;
        for (int c = 0; c < 120; c++) begin
            if (c >= 2) begin
                check("rnd_done", lk_done, vh[1]);
                if (vh[1]) ref_lookup(ah[1], eh, ei, es);
                check("rnd_hit", lk_hit, eh);
                check("rnd_idx", lk_idx, ei);
                check("rnd_sdram", lk_sdram, es);
            end
            vh[1] = vh[0];
            ah[1] = ah[0];
            nv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                na = {8'(tbl[$urandom_range(0, 15) * 16 + 4] + 8'($urandom_range(0, 3))), 8'($urandom)};
            end else begin
                na = 16'($urandom);
            end
            lk_valid = nv;
            lk_addr = na;
            vh[0] = nv;
            ah[0] = na;
            @(negedge clk200);
        end
        lk_valid = 1'b0;
        repeat (3) @(negedge clk200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
